// File: rtl/inperiph_if.sv
// Register bus between the core and the input peripheral: 8-bit address, 32-bit data.
interface inperiph_if;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        wren;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output wren, input rdata);
  modport slave  (input addr, input wdata, input wren, output rdata);
endinterface

// File: rtl/inperiph.sv
// Input peripheral: synchronizes and debounces switches/buttons, latches sticky
// W1C events and raises a level interrupt.
module inperiph #(
  parameter int unsigned SW_W     = 18,
  parameter int unsigned KEY_W    = 4,
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             rst,
  inperiph_if.slave        bus,
  input  logic [SW_W-1:0]  sw,
  input  logic [KEY_W-1:0] key_n,
  output logic             irq
);

  localparam int unsigned IN_W  = SW_W + KEY_W;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  localparam logic [7:0] A_SW   = 8'h00;
  localparam logic [7:0] A_KEY  = 8'h10;
  localparam logic [7:0] A_KEVT = 8'h20;
  localparam logic [7:0] A_SEVT = 8'h30;
  localparam logic [7:0] A_IE   = 8'h40;
  localparam logic [7:0] A_STAT = 8'h50;

  logic [IN_W-1:0]             raw;
  logic [IN_W-1:0]             s1, s2;
  logic [IN_W-1:0]             stable, stable_nxt;
  logic [IN_W-1:0][CNT_W-1:0]  cnt, cnt_nxt;
  logic [KEY_W-1:0]            key_evt, key_evt_nxt;
  logic [SW_W-1:0]             sw_evt, sw_evt_nxt;
  logic                        key_ie, sw_ie;
  logic [SW_W-1:0]             sw_stable;
  logic [KEY_W-1:0]            key_stable;
  logic                        wr_kevt, wr_sevt, wr_ie;

  // Keys are flipped to active-high and conditioned together with the switches.
  assign raw        = {~key_n, sw};
  assign sw_stable  = stable[SW_W-1:0];
  assign key_stable = stable[IN_W-1:SW_W];

  assign wr_kevt = bus.wren && (bus.addr == A_KEVT);
  assign wr_sevt = bus.wren && (bus.addr == A_SEVT);
  assign wr_ie   = bus.wren && (bus.addr == A_IE);

  // Per-bit debounce: stable follows s2 only after DEBOUNCE consecutive differing cycles.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int i = 0; i < int'(IN_W); i++) begin
      if (s2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_nxt[i] = s2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Clear is applied before set so a coincident event keeps the bit high.
  always_comb begin
    key_evt_nxt = key_evt;
    sw_evt_nxt  = sw_evt;
    if (wr_kevt) key_evt_nxt = key_evt_nxt & ~bus.wdata[KEY_W-1:0];
    if (wr_sevt) sw_evt_nxt  = sw_evt_nxt & ~bus.wdata[SW_W-1:0];
    key_evt_nxt = key_evt_nxt | (stable_nxt[IN_W-1:SW_W] & ~key_stable);
    sw_evt_nxt  = sw_evt_nxt | (stable_nxt[SW_W-1:0] ^ sw_stable);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      stable  <= '0;
      cnt     <= '0;
      key_evt <= '0;
      sw_evt  <= '0;
      key_ie  <= 1'b0;
      sw_ie   <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      stable  <= stable_nxt;
      cnt     <= cnt_nxt;
      key_evt <= key_evt_nxt;
      sw_evt  <= sw_evt_nxt;
      if (wr_ie) begin
        key_ie <= bus.wdata[0];
        sw_ie  <= bus.wdata[1];
      end
    end
  end

  assign irq = (|(key_evt & {KEY_W{key_ie}})) | ((|sw_evt) & sw_ie);

  // Zero-latency read mux.
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      A_SW:    bus.rdata = 32'(sw_stable);
      A_KEY:   bus.rdata = 32'(key_stable);
      A_KEVT:  bus.rdata = 32'(key_evt);
      A_SEVT:  bus.rdata = 32'(sw_evt);
      A_IE:    bus.rdata = {30'd0, sw_ie, key_ie};
      A_STAT:  bus.rdata = {29'd0, irq, |sw_evt, |key_evt};
      default: bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_inperiph.sv
// Self-checking bench for inperiph: directed scenarios plus random traffic against a window-based model.
`timescale 1ns/10ps
module tb_inperiph;
  localparam int SW_W = 18;
  localparam int KEY_W = 4;
  localparam int D = 4;
  localparam int IN_W = SW_W + KEY_W;

  logic clk = 1'b0;
  logic rst;
  logic [SW_W-1:0]  sw;
  logic [KEY_W-1:0] key_n;
  logic irq;
  int n_checks = 0;
  int n_errors = 0;

  inperiph_if bus ();

  inperiph #(.SW_W(SW_W), .KEY_W(KEY_W), .DEBOUNCE(D)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sw(sw), .key_n(key_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: history of raw samples; a bit flips when the D synchronized samples
  // seen at the last D edges all disagree with the current stable value.
  logic [IN_W-1:0]  hist[$];
  logic [IN_W-1:0]  m_st;
  logic [KEY_W-1:0] m_kevt;
  logic [SW_W-1:0]  m_sevt;
  logic             m_kie, m_sie;

  function automatic logic [IN_W-1:0] past(int k);
    if (hist.size() > k) return hist[hist.size() - 1 - k];
    return '0;
  endfunction

  function automatic logic m_irq();
    return ((|m_kevt) & m_kie) | ((|m_sevt) & m_sie);
  endfunction

  function automatic logic [31:0] m_read(logic [7:0] a);
    case (a)
      8'h00: return 32'(m_st[SW_W-1:0]);
      8'h10: return 32'(m_st[IN_W-1:SW_W]);
      8'h20: return 32'(m_kevt);
      8'h30: return 32'(m_sevt);
      8'h40: return {30'd0, m_sie, m_kie};
      8'h50: return {29'd0, m_irq(), |m_sevt, |m_kevt};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [IN_W-1:0] nst, smp;
    logic all_diff;
    if (rst) begin
      hist.delete();
      m_st = '0; m_kevt = '0; m_sevt = '0; m_kie = 1'b0; m_sie = 1'b0;
    end else begin
      nst = m_st;
      for (int b = 0; b < IN_W; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++) begin
          smp = past(j);
          if (smp[b] == m_st[b]) all_diff = 1'b0;
        end
        if (all_diff) nst[b] = ~m_st[b];
      end
      if (bus.wren && bus.addr == 8'h20) m_kevt = m_kevt & ~bus.wdata[KEY_W-1:0];
      if (bus.wren && bus.addr == 8'h30) m_sevt = m_sevt & ~bus.wdata[SW_W-1:0];
      if (bus.wren && bus.addr == 8'h40) begin m_kie = bus.wdata[0]; m_sie = bus.wdata[1]; end
      m_kevt = m_kevt | (nst[IN_W-1:SW_W] & ~m_st[IN_W-1:SW_W]);
      m_sevt = m_sevt | (nst[SW_W-1:0] ^ m_st[SW_W-1:0]);
      m_st = nst;
      hist.push_back({~key_n, sw});
      if (hist.size() > D + 2) void'(hist.pop_front());
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    bus.addr = a;
    #0.25;
    v = bus.rdata;
  endtask

  task automatic scan();
    logic [7:0] addrs [9] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'hFF};
    logic [31:0] v;
    foreach (addrs[i]) begin
      rd(addrs[i], v);
      check($sformatf("scan_rd_%02h", addrs[i]), v, m_read(addrs[i]));
    end
    check("scan_irq", 32'(irq), 32'(m_irq()));
  endtask

  task automatic tick(input logic w, input logic [7:0] a, input logic [31:0] d);
    bus.wren = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.wren = 1'b0;
    scan();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 32'd0);
  endtask

  logic [31:0] v;
  logic [7:0] waddr [5] = '{8'h20, 8'h30, 8'h40, 8'h00, 8'h70};

  initial begin
    bus.addr = 8'h00; bus.wdata = '0; bus.wren = 1'b0;
    rst = 1'b1; sw = 18'h2A5A5; key_n = 4'hF;
    @(negedge clk);

    // Reset and settle to the switch pattern after exactly 2+D edges.
    idle(2);
    for (int a = 0; a <= 8'h50; a += 16) begin
      rd(8'(a), v);
      check("reset_rd", v, 32'd0);
    end
    rst = 1'b0;
    idle(5);
    rd(8'h00, v); check("sw_before_settle", v, 32'd0);
    idle(1);
    rd(8'h00, v); check("sw_settled", v, 32'h0002A5A5);
    check("irq_reset_seq", 32'(irq), 32'd0);

    // Re-reset with switches off, then glitch rejection on sw[0].
    sw = '0; rst = 1'b1; idle(1); rst = 1'b0; idle(8);
    sw[0] = 1'b1; idle(3); sw[0] = 1'b0; idle(8);
    rd(8'h00, v); check("glitch_sw", v, 32'd0);
    rd(8'h30, v); check("glitch_evt", v, 32'd0);
    sw[0] = 1'b1; idle(6);
    rd(8'h00, v); check("hold_sw", v, 32'd1);
    rd(8'h30, v); check("hold_evt", v, 32'd1);

    // Key press event with interrupt enabled.
    tick(1'b1, 8'h30, 32'd1);
    tick(1'b1, 8'h40, 32'd1);
    key_n = 4'b1011; idle(6);
    rd(8'h10, v); check("key_stable", v, 32'h4);
    rd(8'h20, v); check("key_evt", v, 32'h4);
    rd(8'h50, v); check("status", v, 32'h5);
    check("irq_key", 32'(irq), 32'd1);
    key_n = 4'hF; idle(6);
    rd(8'h10, v); check("key_release", v, 32'h0);
    rd(8'h20, v); check("evt_sticky", v, 32'h4);

    // W1C semantics.
    tick(1'b1, 8'h20, 32'h0);
    rd(8'h20, v); check("w1c_zero", v, 32'h4);
    tick(1'b1, 8'h20, 32'h4);
    rd(8'h20, v); check("w1c_clear", v, 32'h0);
    check("irq_cleared", 32'(irq), 32'd0);

    // Set wins over a coincident clear.
    key_n[0] = 1'b0; idle(5);
    tick(1'b1, 8'h20, 32'h1);
    rd(8'h20, v); check("set_wins", v, 32'h1);

    // Writes to read-only and unmapped addresses are ignored.
    tick(1'b1, 8'h00, 32'hFFFF_FFFF);
    tick(1'b1, 8'h10, 32'hFFFF_FFFF);
    tick(1'b1, 8'h70, 32'hFFFF_FFFF);
    rd(8'h70, v); check("unmapped_rd", v, 32'h0);
    rd(8'h40, v); check("ie_kept", v, 32'h1);
    rd(8'h20, v); check("kevt_kept", v, 32'h1);
    rd(8'h00, v); check("sw_kept", v, 32'h1);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) sw[$urandom_range(0, SW_W - 1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) key_n[$urandom_range(0, KEY_W - 1)] ^= 1'b1;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0)
        tick(1'b1, waddr[$urandom_range(0, 4)], $urandom);
      else
        tick(1'b0, 8'h00, $urandom);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within bound");
    $fatal(1);
  end
endmodule

// File: doc/inperiph.md
Name: inperiph

Overview:
- Memory-mapped input peripheral: the read-side counterpart of the output peripheral on the same 8-bit address / 32-bit data bus.
- Synchronizes and debounces the board switches and push-buttons, and exposes their stable levels to the core.
- Records sticky key-press and switch-change events with write-1-to-clear semantics.
- Drives a level interrupt request to the core.

Parameters:
- SW_W, 18, number of slide switches (1..32).
- KEY_W, 4, number of push-buttons (1..32).
- DEBOUNCE, 16, consecutive clk cycles a synchronized input must differ from its stable value before the stable value updates (>=1; counter width $clog2(DEBOUNCE+1)).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- addr  input  8  register address.
- wdata  input  32  write data; used only for W1C clears.
- wren  input  1  write enable, sampled on rising clk.
- rdata  output  32  read data; combinational from addr.
- sw  input  SW_W  raw slide switches; asynchronous, 1 = on.
- key_n  input  KEY_W  raw push-buttons; asynchronous, active-low (0 = pressed).
- irq  output  1  level interrupt = |(key_evt & key_ie) | (|sw_evt & sw_ie).

Behaviour:
Reset (rst=1 at a clk edge):
- Clears all synchronizer flops, sw_stable, key_stable, every debounce counter, key_evt, sw_evt, key_ie and sw_ie to 0.
- irq is therefore 0.
- Reset mid-debounce discards partial counts.

Input conditioning:
- key_n is inverted before synchronization, so internally 1 = pressed.
- Each bit passes through a 2-flop synchronizer (s1 -> s2).
- One debounce counter per bit:
  - If s2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE-1: stable <= s2, counter <= 0.
  - Else: counter <= counter+1.
- A change held steady from before edge N appears in s2 after edge N+1; stable updates at edge N+1+DEBOUNCE.
- A glitch shorter than DEBOUNCE cycles in s2 never reaches stable, and its counter restarts at 0.

Event capture:
- key_evt[i] sets on the cycle key_stable[i] rises 0->1 (press only, not release).
- sw_evt[i] sets on any change of sw_stable[i].
- Events are sticky until cleared.
- A write of 1 to an event bit clears it; writing 0 has no effect.
- Set and clear of the same bit in the same cycle: set wins, bit stays 1.

Register map (addr exact match, 16-byte stride):
- 0x00 R: {zero-ext, sw_stable}.
- 0x10 R: {zero-ext, key_stable}.
- 0x20 R/W1C: key_evt.
- 0x30 R/W1C: sw_evt.
- 0x40 R/W: bit0 key_ie, bit1 sw_ie; other bits read 0.
- 0x50 R: status; bit0 = |key_evt, bit1 = |sw_evt, bit2 = irq.
- Reads of any other address return 0.
- Writes to read-only or unmapped addresses are ignored.
- Only wdata bits below the field width are used.

Timing:
- rdata has zero-cycle latency from addr.
- Register writes take effect after the clk edge where wren=1.
- irq is combinational from the registered event and enable bits, so it follows them with no further delay.

Test Plan:
- Reset and read-back: assert rst 2 cycles with sw=18'h2A5A5, key_n=4'hF. Reads of 0x00..0x50 return 0 during reset. 0x00 reads 0x0002A5A5 exactly 2+DEBOUNCE edges after release (DEBOUNCE=4 -> after edge 6); irq=0 throughout.
- Debounce glitch rejection (DEBOUNCE=4): pulse sw[0]=1 for 3 cycles, then 0. Bit 0 of 0x00 stays 0 and sw_evt stays 0. Hold sw[0]=1 for 6 cycles: 0x00 bit0=1 and 0x30 reads 0x1.
- Key press event: write 0x40=0x1, drive key_n=4'b1011. Key 2 is pressed, so after debounce 0x10=0x4, 0x20=0x4, 0x50=0x5 and irq=1. Releasing the key gives 0x10=0, 0x20 still 0x4.
- W1C clear: with key_evt=0x4, writing 0x20=0x0 leaves it at 0x4. Writing 0x20=0x4 gives 0x20=0 and irq=0 the next cycle.
- Simultaneous set and clear: time a W1C write of 0x20=0x1 on the same edge key_stable[0] rises. 0x20 bit0 reads 1 afterwards.
- Unmapped and read-only access: write 0xFFFFFFFF to 0x00, 0x10 and 0x70. All registers are unchanged, and a read of 0x70 returns 0.
